bus_control_sequencer: RTL



---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/unit_onehot_dec.sv | 18 +
 rtl/bus_control_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the bus control sequencer: FSM states, opcodes,
// bus unit indices, ALU op codes and the instruction legality check.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC1  = 3'd3,
    EXEC2  = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_LDM  = 4'd2;
  localparam logic [3:0] OP_STM  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_JMPZ = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [3:0] UNIT_PC = 4'd0;
  localparam logic [3:0] UNIT_AR = 4'd1;
  localparam logic [3:0] UNIT_AC = 4'd2;
  localparam logic [3:0] UNIT_R  = 4'd3;
  localparam logic [3:0] UNIT_IM = 4'd4;
  localparam logic [3:0] UNIT_DM = 4'd5;
  localparam logic [3:0] UNIT_DR = 4'd6;
  localparam logic [3:0] UNIT_A  = 4'd7;
  localparam logic [3:0] UNIT_B  = 4'd8;
  localparam logic [3:0] UNIT_C  = 4'd9;
  localparam logic [3:0] UNIT_D  = 4'd10;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  // Loading the instruction memory from the bus is never allowed for MOV/LDM.
  function automatic logic instr_illegal(input logic [3:0] op,
                                         input logic [3:0] src,
                                         input logic [3:0] dst);
    logic bad_op;
    case (op)
      OP_NOP, OP_MOV, OP_LDM, OP_STM,
      OP_ADD, OP_SUB, OP_JMPZ, OP_HALT: bad_op = 1'b0;
      default:                          bad_op = 1'b1;
    endcase
    return bad_op || (src > UNIT_D) || (dst > UNIT_D) ||
           (((op == OP_MOV) || (op == OP_LDM)) && (dst == UNIT_IM));
  endfunction

endpackage

// File: rtl/unit_onehot_dec.sv
// Index to one-hot bus unit enable decoder; combinational, no backpressure.
// Out-of-range indices or en_i=0 give an all-zero vector.
module unit_onehot_dec #(
  parameter int NUM_UNITS = 11
) (
  input  logic                 en_i,
  input  logic [3:0]           idx_i,
  output logic [NUM_UNITS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      onehot_o[i] = en_i && (idx_i == 4'(i));
    end
  end

endmodule

// File: rtl/bus_control_sequencer.sv
// Fetch/decode/execute control FSM for a shared 16-bit datapath bus; one enable
// set per micro-step, decoded from state and IR (z_flag only in JMPZ EXEC1).
import ctrl_pkg::*;

module bus_control_sequencer #(
  parameter int WIDTH     = 16,
  parameter int NUM_UNITS = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     bus,
  input  logic                 z_flag,
  output logic [NUM_UNITS-1:0] read_en,
  output logic [NUM_UNITS-1:0] write_en,
  output logic [1:0]           alu_op,
  output logic                 pc_inc,
  output logic                 halted,
  output logic                 illegal
);

  state_t           state_q;
  logic [WIDTH-1:0] ir_q;
  logic             illegal_q;
  logic             halted_q;

  logic [3:0] op, src, dst;
  logic       unused_ir;

  assign op        = ir_q[15:12];
  assign src       = ir_q[7:4];
  assign dst       = ir_q[3:0];
  assign unused_ir = ^ir_q[11:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) state_q <= FETCH;
        FETCH: begin
          ir_q    <= bus;
          state_q <= DECODE;
        end
        DECODE: begin
          // An illegal word still costs a fetch slot and then behaves as NOP.
          if (instr_illegal(op, src, dst)) begin
            illegal_q <= 1'b1;
            state_q   <= FETCH;
          end else if (op == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else if (op == OP_NOP) begin
            state_q <= FETCH;
          end else begin
            state_q <= EXEC1;
          end
        end
        EXEC1:   state_q <= (op == OP_LDM) ? EXEC2 : FETCH;
        EXEC2:   state_q <= FETCH;
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic       rd_vld, wr_vld;
  logic [3:0] rd_idx, wr_idx;

  always_comb begin
    rd_vld = 1'b0;
    rd_idx = UNIT_PC;
    wr_vld = 1'b0;
    wr_idx = UNIT_PC;
    alu_op = ALU_PASS;
    pc_inc = 1'b0;
    case (state_q)
      FETCH: begin
        rd_vld = 1'b1;
        rd_idx = UNIT_IM;
        pc_inc = 1'b1;
      end
      EXEC1: begin
        case (op)
          OP_MOV: begin
            rd_vld = 1'b1; rd_idx = src;
            wr_vld = 1'b1; wr_idx = dst;
          end
          OP_LDM: begin
            rd_vld = 1'b1; rd_idx = UNIT_DM;
            wr_vld = 1'b1; wr_idx = UNIT_DR;
          end
          OP_STM: begin
            rd_vld = 1'b1; rd_idx = src;
            wr_vld = 1'b1; wr_idx = UNIT_DM;
          end
          OP_ADD, OP_SUB: begin
            rd_vld = 1'b1; rd_idx = src;
            wr_vld = 1'b1; wr_idx = UNIT_AC;
            alu_op = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
          end
          OP_JMPZ: begin
            rd_vld = z_flag; rd_idx = src;
            wr_vld = z_flag; wr_idx = UNIT_PC;
          end
          default: ;
        endcase
      end
      EXEC2: begin
        rd_vld = 1'b1; rd_idx = UNIT_DR;
        wr_vld = 1'b1; wr_idx = dst;
      end
      default: ;
    endcase
  end

  unit_onehot_dec #(.NUM_UNITS(NUM_UNITS)) u_read_dec (
    .en_i     (rd_vld),
    .idx_i    (rd_idx),
    .onehot_o (read_en)
  );

  unit_onehot_dec #(.NUM_UNITS(NUM_UNITS)) u_write_dec (
    .en_i     (wr_vld),
    .idx_i    (wr_idx),
    .onehot_o (write_en)
  );

  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule
